// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain loader and readback checker.
package ccff_pkg;

  // Chain length of one ble4 tile: 16 LUT bits plus 2 output-mux bits.
  localparam int unsigned BLE4_CCFF_LEN = 18;

  typedef enum logic [2:0] {
    StIdle,
    StWaitByte,
    StShift,
    StDone,
    StErr
  } ccff_state_e;

  // One serial CRC-8 step: MSB-first, implicit x^8, no reflection.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in,
                                           input logic [7:0] poly);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/ccff_crc8.sv
// Serial CRC-8 accumulator; shared by the chain loader and the readback checker.
module ccff_crc8
  import ccff_pkg::*;
#(
  parameter logic [7:0] Poly = 8'h07
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = crc8_step(crc_q, bit_i, Poly);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises a byte-stream bitstream MSB-first onto the tile configuration chain and
// accumulates a CRC-8 over the previous contents leaving the chain tail.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = BLE4_CCFF_LEN,
  parameter logic [7:0]  CRC_POLY  = 8'h07
) (
  input  logic       prog_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] cfg_data,
  input  logic       cfg_valid,
  input  logic       cfg_last,
  output logic       cfg_ready,
  output logic       ccff_head,
  output logic       chain_shift_en,
  input  logic       ccff_tail,
  output logic       busy,
  output logic       done,
  output logic       err_short,
  output logic       err_long,
  output logic [7:0] tail_crc
);

  localparam int unsigned     CntW        = $clog2(CHAIN_LEN + 1);
  localparam logic [CntW-1:0] ChainLenCnt = CntW'(CHAIN_LEN);

  ccff_state_e     state_q, state_d;
  logic [CntW-1:0] bits_done_q, bits_done_d, bits_done_inc;
  logic [3:0]      rem_q, rem_d, rem_init;
  logic [7:0]      shreg_q, shreg_d;
  logic            last_q, last_d;
  logic            head_q, head_d;
  logic            shift_en_q, shift_en_d;
  logic            done_q, done_d;
  logic            err_short_q, err_short_d;
  logic            err_long_q, err_long_d;
  logic            crc_clear, crc_en;
  int unsigned     bits_left;

  assign bits_done_inc = bits_done_q + CntW'(1);
  assign bits_left     = CHAIN_LEN - 32'(bits_done_q);
  // Final byte may carry padding beyond the chain; only the needed bits are shifted.
  assign rem_init      = (bits_left >= 32'd8) ? 4'd8 : 4'(bits_left);

  always_ff @(posedge prog_clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bits_done_d = bits_done_q;
    rem_d       = rem_q;
    shreg_d     = shreg_q;
    last_d      = last_q;
    head_d      = 1'b0;
    shift_en_d  = 1'b0;
    done_d      = done_q;
    err_short_d = err_short_q;
    err_long_d  = err_long_q;
    crc_clear   = 1'b0;
    crc_en      = 1'b0;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d     = StWaitByte;
          bits_done_d = '0;
          done_d      = 1'b0;
          err_short_d = 1'b0;
          err_long_d  = 1'b0;
          crc_clear   = 1'b1;
        end
      end
      StWaitByte: begin
        if (cfg_valid) begin
          // shreg keeps the not-yet-presented bits aligned at bit 7
          shreg_d    = {cfg_data[6:0], 1'b0};
          last_d     = cfg_last;
          rem_d      = rem_init;
          head_d     = cfg_data[7];
          shift_en_d = 1'b1;
          state_d    = StShift;
        end
      end
      StShift: begin
        // Every StShift cycle ends in a chain capture edge.
        crc_en      = 1'b1;
        bits_done_d = bits_done_inc;
        rem_d       = rem_q - 4'd1;
        shreg_d     = {shreg_q[6:0], 1'b0};
        if (rem_q == 4'd1) begin
          if (bits_done_inc == ChainLenCnt) begin
            if (last_q) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d    = StErr;
              err_long_d = 1'b1;
            end
          end else if (last_q) begin
            state_d     = StErr;
            err_short_d = 1'b1;
          end else begin
            state_d = StWaitByte;
          end
        end else begin
          head_d     = shreg_q[7];
          shift_en_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    cfg_ready = 1'b0;
    unique case (state_q)
      StWaitByte: begin
        busy      = 1'b1;
        cfg_ready = 1'b1;
      end
      StShift: busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge prog_clk or posedge reset) begin
    if (reset) begin
      bits_done_q <= '0;
      rem_q       <= '0;
      shreg_q     <= '0;
      last_q      <= 1'b0;
      head_q      <= 1'b0;
      shift_en_q  <= 1'b0;
      done_q      <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      bits_done_q <= bits_done_d;
      rem_q       <= rem_d;
      shreg_q     <= shreg_d;
      last_q      <= last_d;
      head_q      <= head_d;
      shift_en_q  <= shift_en_d;
      done_q      <= done_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
    end
  end

  ccff_crc8 #(
    .Poly(CRC_POLY)
  ) u_crc (
    .clk_i  (prog_clk),
    .reset_i(reset),
    .clear_i(crc_clear),
    .en_i   (crc_en),
    .bit_i  (ccff_tail),
    .crc_o  (tail_crc)
  );

  assign ccff_head      = head_q;
  assign chain_shift_en = shift_en_q;
  assign done           = done_q;
  assign err_short      = err_short_q;
  assign err_long       = err_long_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: behavioural chain, byte-level bitstream model, CRC reference.
module tb_ccff_chain_loader;

  localparam int N = 18;

  logic       prog_clk = 1'b0;
  logic       reset, start, cfg_valid, cfg_last, cfg_ready;
  logic       ccff_head, chain_shift_en, ccff_tail, busy, done, err_short, err_long;
  logic [7:0] cfg_data, tail_crc;

  int errors = 0;
  int checks = 0;

  ccff_chain_loader #(
    .CHAIN_LEN(N),
    .CRC_POLY (8'h07)
  ) dut (
    .prog_clk      (prog_clk),
    .reset         (reset),
    .start         (start),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_last      (cfg_last),
    .cfg_ready     (cfg_ready),
    .ccff_head     (ccff_head),
    .chain_shift_en(chain_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .err_short     (err_short),
    .err_long      (err_long),
    .tail_crc      (tail_crc)
  );

  always #5 prog_clk = ~prog_clk;

  // Behavioural configuration chain: head enters bit 0, tail is bit N-1.
  logic [N-1:0] chain;
  logic         chain_clr;
  always @(posedge prog_clk) begin
    if (chain_clr) chain <= '0;
    else if (chain_shift_en) chain <= {chain[N-2:0], ccff_head};
  end
  assign ccff_tail = chain[N-1];

  // Observed head bits, plus illegal-shift counter.
  logic head_log[$];
  int   shift_bad = 0;
  always @(negedge prog_clk) begin
    if (chain_shift_en) head_log.push_back(ccff_head);
    if (chain_shift_en && (cfg_ready || !busy)) shift_bad++;
  end

  // Reference chain contents, front = bit that leaves the tail next.
  logic ref_chain[$];

  logic [7:0]  ld_data[8];
  logic        ld_last[8];
  int          ld_n;
  logic        exp_bits[$];
  int          got_shifts;
  logic [31:0] got_vec, exp_vec;
  logic        exp_done, exp_short, exp_long, extra_ready_seen;
  logic [7:0]  exp_crc;

  function automatic logic [7:0] ref_crc_step(input logic [7:0] c, input logic b);
    logic [8:0] r;
    r = {c, 1'b0};
    if (c[7] ^ b) r = r ^ 9'h107;
    return r[7:0];
  endfunction

  task automatic chain_reset();
    chain_clr = 1'b1;
    @(negedge prog_clk);
    chain_clr = 1'b0;
    ref_chain.delete();
    for (int i = 0; i < N; i++) ref_chain.push_back(1'b0);
  endtask

  task automatic do_load(input int max_gap, input bit valid_with_start, input bit offer_extra);
    int   done_bits, n, acc, base, t;
    logic out_bit;
    exp_bits.delete();
    done_bits = 0;
    acc       = 0;
    for (int i = 0; i < ld_n; i++) begin
      n = (N - done_bits >= 8) ? 8 : N - done_bits;
      for (int j = 0; j < n; j++) exp_bits.push_back(ld_data[i][7-j]);
      done_bits += n;
      acc = i + 1;
      if (ld_last[i] || done_bits == N) break;
    end
    exp_done  = (done_bits == N) && ld_last[acc-1];
    exp_long  = (done_bits == N) && !ld_last[acc-1];
    exp_short = (done_bits < N);
    exp_crc   = 8'h00;
    exp_vec   = '0;
    foreach (exp_bits[k]) begin
      out_bit = ref_chain.pop_front();
      ref_chain.push_back(exp_bits[k]);
      exp_crc = ref_crc_step(exp_crc, out_bit);
      exp_vec = {exp_vec[30:0], exp_bits[k]};
    end

    base = head_log.size();
    extra_ready_seen = 1'b0;
    @(negedge prog_clk);
    start = 1'b1;
    if (valid_with_start) begin
      cfg_valid = 1'b1;
      cfg_data  = ld_data[0];
      cfg_last  = ld_last[0];
    end
    @(negedge prog_clk);
    start = 1'b0;
    for (int i = 0; i < acc; i++) begin
      if (!(i == 0 && valid_with_start)) begin
        cfg_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) @(negedge prog_clk);
        cfg_valid = 1'b1;
        cfg_data  = ld_data[i];
        cfg_last  = ld_last[i];
      end
      t = 0;
      while (!cfg_ready && t < 40) begin
        @(negedge prog_clk);
        t++;
      end
      if (!cfg_ready) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout byte %0d: cfg_ready=0 required 1", i);
        break;
      end
      @(negedge prog_clk);
    end
    if (offer_extra) begin
      cfg_valid = 1'b1;
      cfg_data  = ld_data[acc];
      cfg_last  = 1'b1;
    end else begin
      cfg_valid = 1'b0;
    end
    t = 0;
    while (busy && t < 40) begin
      if (cfg_ready && cfg_valid) extra_ready_seen = 1'b1;
      @(negedge prog_clk);
      t++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: busy=1 required 0");
    end
    if (offer_extra) begin
      repeat (3) begin
        if (cfg_ready) extra_ready_seen = 1'b1;
        @(negedge prog_clk);
      end
    end
    cfg_valid  = 1'b0;
    got_shifts = head_log.size() - base;
    got_vec    = '0;
    for (int k = 0; k < got_shifts && k < 32; k++) got_vec = {got_vec[30:0], head_log[base+k]};
  endtask

  task automatic test_reset();
    repeat (2) @(negedge prog_clk);
    checks++;
    if ({busy, cfg_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_busy_ready: got %b required 00", {busy, cfg_ready});
    end
    checks++;
    if ({done, err_short, err_long} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b required 000", {done, err_short, err_long});
    end
    checks++;
    if ({ccff_head, chain_shift_en} !== 2'b00) begin
      errors++; $display("FAIL reset_head_en: got %b required 00", {ccff_head, chain_shift_en});
    end
    checks++;
    if (tail_crc !== 8'h00) begin
      errors++; $display("FAIL reset_crc: got %h required 00", tail_crc);
    end
    reset = 1'b0;
    chain_clr = 1'b0;
    // A byte offered without start must not be taken.
    cfg_valid = 1'b1;
    cfg_data  = 8'hFF;
    repeat (4) @(negedge prog_clk);
    cfg_valid = 1'b0;
    checks++;
    if ({busy, chain_shift_en, head_log.size() == 0} !== 3'b001) begin
      errors++; $display("FAIL idle_no_accept: busy/en/noshift=%b required 001",
                         {busy, chain_shift_en, head_log.size() == 0});
    end
  endtask

  task automatic test_basic();
    ld_data[0] = 8'hA5; ld_last[0] = 1'b0;
    ld_data[1] = 8'h3C; ld_last[1] = 1'b0;
    ld_data[2] = 8'hC0; ld_last[2] = 1'b1;
    ld_n = 3;
    do_load(0, 1'b1, 1'b0);
    checks++;
    if (got_shifts !== 18) begin
      errors++; $display("FAIL basic_shifts: got %0d required 18", got_shifts);
    end
    checks++;
    if (got_vec[17:0] !== 18'b1010_0101_0011_1100_11) begin
      errors++; $display("FAIL basic_head_seq: got %b required 101001010011110011", got_vec[17:0]);
    end
    checks++;
    if ({done, err_short, err_long} !== 3'b100) begin
      errors++; $display("FAIL basic_flags: got %b required 100", {done, err_short, err_long});
    end
    checks++;
    if (tail_crc !== exp_crc) begin
      errors++; $display("FAIL basic_crc: got %h required %h", tail_crc, exp_crc);
    end
  endtask

  task automatic test_short();
    ld_data[0] = 8'hA5; ld_last[0] = 1'b0;
    ld_data[1] = 8'h3C; ld_last[1] = 1'b1;
    ld_n = 2;
    do_load(0, 1'b0, 1'b0);
    checks++;
    if (got_shifts !== 16) begin
      errors++; $display("FAIL short_shifts: got %0d required 16", got_shifts);
    end
    checks++;
    if ({done, err_short, err_long} !== 3'b010) begin
      errors++; $display("FAIL short_flags: got %b required 010", {done, err_short, err_long});
    end
    checks++;
    if (tail_crc !== exp_crc) begin
      errors++; $display("FAIL short_crc: got %h required %h", tail_crc, exp_crc);
    end
    ld_data[1] = 8'h3C; ld_last[1] = 1'b0;
    ld_data[2] = 8'hC0; ld_last[2] = 1'b1;
    ld_n = 3;
    do_load(1, 1'b0, 1'b0);
    checks++;
    if ({done, err_short, err_long} !== 3'b100) begin
      errors++; $display("FAIL short_reload_flags: got %b required 100", {done, err_short, err_long});
    end
  endtask

  task automatic test_long();
    ld_data[0] = 8'h5A; ld_last[0] = 1'b0;
    ld_data[1] = 8'hC3; ld_last[1] = 1'b0;
    ld_data[2] = 8'h80; ld_last[2] = 1'b0;
    ld_data[3] = 8'h77; ld_last[3] = 1'b1;
    ld_n = 3;
    do_load(0, 1'b0, 1'b1);
    checks++;
    if (got_shifts !== 18) begin
      errors++; $display("FAIL long_shifts: got %0d required 18", got_shifts);
    end
    checks++;
    if ({done, err_short, err_long} !== 3'b001) begin
      errors++; $display("FAIL long_flags: got %b required 001", {done, err_short, err_long});
    end
    checks++;
    if (extra_ready_seen !== 1'b0) begin
      errors++; $display("FAIL long_byte4_refused: ready_seen=%b required 0", extra_ready_seen);
    end
  endtask

  task automatic test_readback();
    logic [7:0] p_crc;
    logic [7:0] p[3];
    int         nb;
    chain_reset();
    for (int i = 0; i < 3; i++) begin
      p[i] = 8'($urandom);
      ld_data[i] = p[i];
      ld_last[i] = (i == 2);
    end
    ld_n = 3;
    do_load(0, 1'b0, 1'b0);
    checks++;
    if (tail_crc !== 8'h00) begin
      errors++; $display("FAIL readback_first_crc: got %h required 00", tail_crc);
    end
    // CRC of P's 18 bits straight from the bytes, independent of the chain queue.
    p_crc = 8'h00;
    nb = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 7; j >= 0; j--)
        if (nb < N) begin
          p_crc = ref_crc_step(p_crc, p[i][j]);
          nb++;
        end
    for (int i = 0; i < 3; i++) ld_data[i] = 8'($urandom);
    do_load(2, 1'b0, 1'b0);
    checks++;
    if (tail_crc !== p_crc) begin
      errors++; $display("FAIL readback_second_crc: got %h required %h", tail_crc, p_crc);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL readback_done: got %b required 1", done);
    end
  endtask

  task automatic test_random_gaps();
    int mode;
    for (int it = 0; it < 12; it++) begin
      mode = int'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) begin
        ld_data[i] = 8'($urandom);
        ld_last[i] = 1'b0;
      end
      case (mode)
        0: begin ld_n = 3; ld_last[2] = 1'b1; end
        1: begin ld_n = 2; ld_last[1] = 1'b1; end
        2: ld_n = 3;
        default: begin ld_n = 1; ld_last[0] = 1'b1; end
      endcase
      do_load(5, 1'b0, 1'b0);
      checks++;
      if (got_shifts !== exp_bits.size() || got_vec !== exp_vec) begin
        errors++; $display("FAIL gaps_head it%0d: got %0d/%h required %0d/%h", it, got_shifts,
                           got_vec, exp_bits.size(), exp_vec);
      end
      checks++;
      if ({done, err_short, err_long} !== {exp_done, exp_short, exp_long}) begin
        errors++; $display("FAIL gaps_flags it%0d: got %b required %b", it,
                           {done, err_short, err_long}, {exp_done, exp_short, exp_long});
      end
      checks++;
      if (tail_crc !== exp_crc) begin
        errors++; $display("FAIL gaps_crc it%0d: got %h required %h", it, tail_crc, exp_crc);
      end
    end
    checks++;
    if (shift_bad !== 0) begin
      errors++; $display("FAIL no_shift_while_waiting: got %0d required 0", shift_bad);
    end
  endtask

  task automatic test_reset_mid();
    int base, t;
    base = head_log.size();
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start     = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = 8'($urandom);
    cfg_last  = 1'b0;
    t = 0;
    while (head_log.size() - base < 10 && t < 60) begin
      @(negedge prog_clk);
      #1;
      t++;
    end
    checks++;
    if (head_log.size() - base < 10) begin
      errors++; $display("FAIL midreset_reach: shifts %0d required 10", head_log.size() - base);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, cfg_ready, ccff_head, chain_shift_en, done, err_short, err_long, tail_crc} !== 15'd0)
    begin
      errors++; $display("FAIL midreset_async: got %b required all 0",
                         {busy, cfg_ready, ccff_head, chain_shift_en, done, err_short, err_long,
                          tail_crc});
    end
    cfg_valid = 1'b0;
    start = 1'b1;
    repeat (2) @(posedge prog_clk);
    @(negedge prog_clk);
    start = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(negedge prog_clk);
    checks++;
    if ({busy, cfg_ready} !== 2'b00) begin
      errors++; $display("FAIL midreset_start_ignored: got %b required 00", {busy, cfg_ready});
    end
    chain_reset();
    for (int i = 0; i < 3; i++) begin
      ld_data[i] = 8'($urandom);
      ld_last[i] = (i == 2);
    end
    ld_n = 3;
    do_load(1, 1'b0, 1'b0);
    checks++;
    if ({done, err_short, err_long} !== 3'b100 || got_vec !== exp_vec) begin
      errors++; $display("FAIL midreset_reload: flags %b head %h required 100 %h",
                         {done, err_short, err_long}, got_vec, exp_vec);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    cfg_data  = 8'h00;
    chain_clr = 1'b1;
    for (int i = 0; i < N; i++) ref_chain.push_back(1'b0);
    test_reset();
    test_basic();
    test_short();
    test_long();
    test_readback();
    test_random_gaps();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
